uart_autobaud: RTL and testbench
================================

UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flip-flops in the rx line synchronizer (legal range 2..4).
REQ-002 SHALL have parameter MIN_DIV, default 16'd16, smallest accepted cycles-per-bit result.
REQ-003 SHALL have one clock and an asynchronous active-high reset:
  clk_i  input  1  rising-edge clock.
  rst_i  input  1  reset; asynchronous assert, active high.
REQ-004 SHALL have the remaining ports:
  en_i        input   1   arm detection; level; deassert aborts.
  rx_i        input   1   raw asynchronous serial line; idle high.
  rx_o        output  1   synchronized line, for the downstream uart rx input.
  baud_div_o  output  16  measured cycles per bit, in the same units as the uart baud_div field.
  done_o      output  1   one-cycle pulse; new baud_div_o is valid.
  err_o       output  1   one-cycle pulse; measurement rejected.
  busy_o      output  1   high whenever the FSM is not IDLE.

Function
REQ-005 SHALL pass rx_i through SYNC_STAGES flip-flops; rx_o is the last stage, latency SYNC_STAGES cycles.
REQ-006 SHALL detect edges on rx_o against one extra registered copy; all FSM decisions use rx_o only.
REQ-007 SHALL implement FSM states IDLE, ARM, WAIT_START, WAIT_RISE, MEASURE.
REQ-008 IDLE -> ARM when en_i=1.
REQ-009 ARM SHALL count consecutive cycles with rx_o=1 and go to WAIT_START after 16 cycles; any rx_o=0 restarts the count.
REQ-010 WAIT_START -> WAIT_RISE on a falling edge, clearing the counter.
REQ-011 WAIT_RISE -> MEASURE on the first rising edge (end of start bit), clearing the counter and setting the rise count to 0.
REQ-012 MEASURE SHALL increment a 19-bit counter every cycle and the rise count on each rising edge; on the 4th rising edge, which for calibration byte 0x55 is the stop-bit rising edge 8 bit times later, it SHALL evaluate the result.
REQ-013 Evaluation SHALL compute div = (cnt + 4) >> 3, where cnt includes the edge cycle, i.e. round to nearest.
REQ-014 If div >= MIN_DIV and div <= 16'hFFFF, baud_div_o SHALL load div, done_o SHALL pulse the next cycle, and the FSM SHALL go to IDLE.
REQ-015 Otherwise baud_div_o SHALL hold its value, err_o SHALL pulse, and the FSM SHALL go to IDLE.
REQ-016 Counter saturation (all ones) in WAIT_RISE or MEASURE SHALL cause err_o and a return to IDLE; the counter never wraps.
REQ-017 en_i=0 in any non-IDLE state SHALL return to IDLE within one cycle, without a done_o or err_o pulse and without changing baud_div_o.
REQ-018 If en_i stays high after done_o or err_o, the FSM SHALL re-arm (IDLE -> ARM) on the next cycle.
REQ-019 done_o and err_o SHALL never assert in the same cycle.
REQ-020 baud_div_o SHALL change only on a successful evaluation.

Reset
REQ-021 While rst_i=1: FSM=IDLE, all counters=0, synchronizer stages and edge register=1, rx_o=1, baud_div_o=0, done_o=0, err_o=0, busy_o=0.
REQ-022 Reset asserted mid-measurement SHALL discard the measurement with no pulse on done_o or err_o.

Structure
REQ-023 The FSM state enum and the constants ARM_IDLE_CYCLES=16 and MEAS_BITS=8 SHALL live in ceres_param.
REQ-024 The synchronizer SHALL be a sub-module named sync_ff, parameterised by depth and reset value.

Verification
REQ-025 Send 0x55 8N1 at 434 cycles/bit with en_i=1 -> done_o pulses once, baud_div_o=434, busy_o returns to 0.
REQ-026 Send 0x55 at 20 cycles/bit with 3-cycle jitter on edges -> baud_div_o=20 ±1, done_o pulse.
REQ-027 Send 0x55 at 8 cycles/bit with MIN_DIV=16 -> err_o pulses, baud_div_o keeps its previous value.
REQ-028 Hold rx_i low for 2^19 cycles after the start edge -> err_o pulses and the FSM returns to IDLE.
REQ-029 Drop en_i midway through MEASURE -> no done_o or err_o, baud_div_o unchanged, busy_o=0 next cycle.
REQ-030 Assert rst_i during MEASURE, then release and resend 0x55 at 100 cycles/bit -> all outputs at reset values during reset, then baud_div_o=100.

Source files
------------

// File: rtl/ceres_param.sv
// ---------------------------------------------------------------------------
// ceres_param
//   Shared definitions for the UART auto-baud detector.
//   - state_e          : detector FSM states
//   - ARM_IDLE_CYCLES  : idle-high cycles required before a start bit is trusted
//   - MEAS_BITS        : bit times spanned by one measurement window
//   - MEAS_RISES       : rising edges seen inside the window for 0x55
//   - CNT_W_DEFAULT    : default width of the measurement counter
//   - round_div()      : cycles-per-window -> cycles-per-bit, rounded to nearest
// ---------------------------------------------------------------------------
package ceres_param;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_RISE  = 3'd3,
    ST_MEASURE    = 3'd4
  } state_e;

  localparam int ARM_IDLE_CYCLES = 16;
  localparam int MEAS_BITS       = 8;
  // 0x55 sent LSB first alternates every bit, so a window of MEAS_BITS bit
  // times after the end of the start bit contains MEAS_BITS/2 rising edges.
  localparam int MEAS_RISES      = MEAS_BITS / 2;
  localparam int DIV_SHIFT       = $clog2(MEAS_BITS);
  localparam int CNT_W_DEFAULT   = 19;

  // Adding half a divisor before the shift rounds to the nearest integer.
  function automatic logic [31:0] round_div(input logic [31:0] cycles);
    return (cycles + 32'(MEAS_BITS / 2)) >> DIV_SHIFT;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
//   Multi-stage flip-flop synchronizer for a single asynchronous bit.
//   Parameters : DEPTH   - number of flip-flops (>= 2)
//                RST_VAL - value every stage takes while reset is asserted
//   Ports      : clk_i   - rising-edge clock
//                rst_i   - asynchronous active-high reset
//                d_i     - asynchronous input
//                q_o     - synchronized output, DEPTH cycles of latency
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] stage_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_reg <= {DEPTH{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_reg[DEPTH-1];

endmodule

// File: rtl/uart_autobaud.sv
// ---------------------------------------------------------------------------
// uart_autobaud
//   Measures the bit period of a 0x55 calibration byte on a raw serial line
//   and reports it as clock cycles per bit.
//   Parameters : SYNC_STAGES - rx synchronizer depth (2..4)
//                MIN_DIV     - smallest accepted cycles-per-bit result
//                CNT_W       - measurement counter width
//   Ports      : clk_i       - rising-edge clock
//                rst_i       - asynchronous active-high reset
//                en_i        - arm detection (level); dropping it aborts
//                rx_i        - raw asynchronous serial line, idle high
//                rx_o        - synchronized line for the downstream receiver
//                baud_div_o  - last accepted cycles-per-bit measurement
//                done_o      - one-cycle pulse, baud_div_o was updated
//                err_o       - one-cycle pulse, measurement rejected
//                busy_o      - FSM is not idle
// ---------------------------------------------------------------------------
module uart_autobaud
  import ceres_param::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MIN_DIV     = 16'd16,
  parameter int          CNT_W       = CNT_W_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        rx_i,
  output logic        rx_o,
  output logic [15:0] baud_div_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o
);

  logic             rx_sync;
  logic             rx_q_reg;
  logic             rise;
  logic             fall;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       rise_cnt_reg, rise_cnt_next;
  logic [15:0]      baud_div_reg, baud_div_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic [31:0]      meas_cycles;
  logic [31:0]      div_calc;
  logic             div_ok;
  logic             cnt_sat;

  sync_ff #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_sync)
  );

  assign rx_o = rx_sync;

  // One extra copy of the synchronized line gives edge detection that never
  // looks at the metastable stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_q_reg <= 1'b1;
    end else begin
      rx_q_reg <= rx_sync;
    end
  end

  assign rise = rx_sync & ~rx_q_reg;
  assign fall = ~rx_sync & rx_q_reg;

  // The counter is cleared on the cycle of the first rising edge and counts
  // every cycle after it, so adding one includes the closing edge cycle.
  assign meas_cycles = 32'(cnt_reg) + 32'd1;
  assign div_calc    = round_div(meas_cycles);
  assign div_ok      = (div_calc >= 32'(MIN_DIV)) && (div_calc <= 32'h0000_FFFF);
  assign cnt_sat     = &cnt_reg;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rise_cnt_next = rise_cnt_reg;
    baud_div_next = baud_div_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (state_reg == ST_IDLE) begin
      cnt_next      = '0;
      rise_cnt_next = '0;
      if (en_i) begin
        state_next = ST_ARM;
      end
    end else if (!en_i) begin
      // Silent abort: no pulse, result register untouched.
      state_next    = ST_IDLE;
      cnt_next      = '0;
      rise_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_ARM: begin
          if (!rx_sync) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_W'(ARM_IDLE_CYCLES - 1)) begin
            state_next = ST_WAIT_START;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        ST_WAIT_START: begin
          if (fall) begin
            state_next = ST_WAIT_RISE;
            cnt_next   = '0;
          end
        end

        ST_WAIT_RISE: begin
          if (rise) begin
            state_next    = ST_MEASURE;
            cnt_next      = '0;
            rise_cnt_next = '0;
          end else if (cnt_sat) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            err_next   = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        ST_MEASURE: begin
          if (rise && (rise_cnt_reg == 3'(MEAS_RISES - 1))) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            rise_cnt_next = '0;
            if (div_ok) begin
              baud_div_next = div_calc[15:0];
              done_next     = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end else if (cnt_sat) begin
            state_next    = ST_IDLE;
            cnt_next      = '0;
            rise_cnt_next = '0;
            err_next      = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
            if (rise) begin
              rise_cnt_next = rise_cnt_reg + 3'd1;
            end
          end
        end

        default: begin
          state_next    = ST_IDLE;
          cnt_next      = '0;
          rise_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      rise_cnt_reg <= '0;
      baud_div_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rise_cnt_reg <= rise_cnt_next;
      baud_div_reg <= baud_div_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign baud_div_o = baud_div_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;
  assign busy_o     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_autobaud.sv
// ---------------------------------------------------------------------------
// tb_uart_autobaud
//   Directed bench for uart_autobaud: sends 0x55 calibration frames at several
//   bit rates (with and without edge jitter), plus abort, saturation and
//   mid-measurement reset scenarios. A narrow measurement counter keeps the
//   saturation case short.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_autobaud;

  localparam int CNT_W_TB = 13;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        rx_i;
  logic        rx_o;
  logic [15:0] baud_div_o;
  logic        done_o;
  logic        err_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  int   done_cnt      = 0;
  int   err_cnt       = 0;
  int   both_cnt      = 0;
  logic busy_at_pulse = 1'b1;

  // Edge displacement (cycles) for frame edges 0..10 in the jitter test.
  int jit_tab [11] = '{0, 3, -3, 2, -1, 3, -2, 1, -3, -3, 0};

  uart_autobaud #(
    .SYNC_STAGES (2),
    .MIN_DIV     (16'd16),
    .CNT_W       (CNT_W_TB)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .rx_i       (rx_i),
    .rx_o       (rx_o),
    .baud_div_o (baud_div_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (done_o) done_cnt <= done_cnt + 1;
      if (err_o)  err_cnt  <= err_cnt + 1;
      if (done_o && err_o) both_cnt <= both_cnt + 1;
      if (done_o || err_o) busy_at_pulse <= busy_o;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // 8N1 frame, LSB first; frame bit k lasts from edge k to edge k+1.
  task automatic send_byte(input logic [7:0] data, input int bit_cycles, input bit use_jit);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int k = 0; k < 10; k++) begin
      int dur;
      dur = bit_cycles + (use_jit ? (jit_tab[k+1] - jit_tab[k]) : 0);
      rx_i = frame[k];
      idle(dur);
    end
  endtask

  task automatic report(input string name);
    $display("tx %s: baud_div=%0d done_cnt=%0d err_cnt=%0d busy=%0d",
             name, baud_div_o, done_cnt, err_cnt, busy_o);
  endtask

  initial begin
    rst_i = 1'b1;
    en_i  = 1'b0;
    rx_i  = 1'b1;
    idle(4);
    check_val("rst_rx_o",  32'(rx_o),   32'd1);
    check_val("rst_baud",  32'(baud_div_o), 32'd0);
    check_val("rst_done",  32'(done_o), 32'd0);
    check_val("rst_err",   32'(err_o),  32'd0);
    check_val("rst_busy",  32'(busy_o), 32'd0);
    rst_i = 1'b0;
    idle(2);

    // 0x55 at 434 cycles/bit
    en_i = 1'b1;
    idle(40);
    check_val("armed_busy", 32'(busy_o), 32'd1);
    send_byte(8'h55, 434, 1'b0);
    report("0x55@434");
    check_val("b434_done_cnt", done_cnt, 32'd1);
    check_val("b434_err_cnt",  err_cnt,  32'd0);
    check_val("b434_div",      32'(baud_div_o), 32'd434);
    check_val("b434_idle_at_pulse", 32'(busy_at_pulse), 32'd0);
    check_val("b434_rearm_busy", 32'(busy_o), 32'd1);
    en_i = 1'b0;
    idle(1);
    check_val("disarm_busy", 32'(busy_o), 32'd0);

    // 0x55 at 20 cycles/bit with jitter: window = 160 - 3 - 3 = 154 -> 19
    en_i = 1'b1;
    idle(40);
    send_byte(8'h55, 20, 1'b1);
    idle(20);
    report("0x55@20 jitter");
    check_val("jit_done_cnt", done_cnt, 32'd2);
    check_val("jit_err_cnt",  err_cnt,  32'd0);
    check_val("jit_div",      32'(baud_div_o), 32'd19);
    check_val("jit_div_in_tol", 32'(baud_div_o >= 16'd19 && baud_div_o <= 16'd21), 32'd1);

    // 0x55 at 8 cycles/bit: div 8 < MIN_DIV -> rejected
    idle(40);
    send_byte(8'h55, 8, 1'b0);
    idle(20);
    report("0x55@8");
    check_val("fast_err_cnt",  err_cnt,  32'd1);
    check_val("fast_done_cnt", done_cnt, 32'd2);
    check_val("fast_div_held", 32'(baud_div_o), 32'd19);

    // Drop en_i in the middle of MEASURE
    idle(40);
    fork
      send_byte(8'h55, 100, 1'b0);
      begin
        idle(400);
        check_val("abort_busy_before", 32'(busy_o), 32'd1);
        en_i = 1'b0;
        idle(1);
        check_val("abort_busy_after", 32'(busy_o), 32'd0);
      end
    join
    idle(20);
    report("0x55@100 abort");
    check_val("abort_done_cnt", done_cnt, 32'd2);
    check_val("abort_err_cnt",  err_cnt,  32'd1);
    check_val("abort_div_held", 32'(baud_div_o), 32'd19);

    // Line stuck low after the start edge -> counter saturates
    en_i = 1'b1;
    idle(40);
    rx_i = 1'b0;
    idle((2 ** CNT_W_TB) + 100);
    rx_i = 1'b1;
    idle(40);
    report("stuck low");
    check_val("sat_err_cnt",  err_cnt,  32'd2);
    check_val("sat_done_cnt", done_cnt, 32'd2);
    check_val("sat_div_held", 32'(baud_div_o), 32'd19);
    check_val("sat_idle_at_pulse", 32'(busy_at_pulse), 32'd0);

    // Reset in the middle of MEASURE, then a clean 100 cycles/bit frame
    fork
      send_byte(8'h55, 100, 1'b0);
      begin
        idle(500);
        rst_i = 1'b1;
        idle(3);
        check_val("mrst_rx_o", 32'(rx_o),   32'd1);
        check_val("mrst_baud", 32'(baud_div_o), 32'd0);
        check_val("mrst_done", 32'(done_o), 32'd0);
        check_val("mrst_err",  32'(err_o),  32'd0);
        check_val("mrst_busy", 32'(busy_o), 32'd0);
      end
    join
    report("0x55@100 reset");
    check_val("mrst_done_cnt", done_cnt, 32'd2);
    check_val("mrst_err_cnt",  err_cnt,  32'd2);
    rst_i = 1'b0;
    idle(40);
    send_byte(8'h55, 100, 1'b0);
    idle(20);
    report("0x55@100");
    check_val("b100_div",      32'(baud_div_o), 32'd100);
    check_val("b100_done_cnt", done_cnt, 32'd3);
    check_val("b100_err_cnt",  err_cnt,  32'd2);

    check_val("done_err_overlap", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
